// File: rtl/tt_lab17_pkg.sv
// Shared types and pin indices for the lab-group 17 frame reader tile.
package tt_lab17_pkg;

    typedef enum logic [1:0] {
        ST_ACC    = 2'd0,
        ST_RES_LO = 2'd1,
        ST_RES_HI = 2'd2
    } state_e;

    localparam int unsigned UIO_VALID     = 0;
    localparam int unsigned UIO_LAST      = 1;
    localparam int unsigned UIO_ACK       = 2;
    localparam int unsigned UIO_READY     = 4;
    localparam int unsigned UIO_RES_VALID = 5;
    localparam int unsigned UIO_RES_HI    = 6;
    localparam int unsigned UIO_OVF       = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/tt_um_labgroup17_frame_reader_frame_accumulator.sv
// Per-frame 16-bit modular sum with sticky carry-out and an 8-bit word count.
module frame_accumulator
    import tt_lab17_pkg::*;
#(
    parameter bit CNT_SAT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] sum_o,
    output logic [7:0]  cnt_o,
    output logic        ovf_o
);

    logic [15:0] sum_q, sum_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [16:0] add;

    assign add = {1'b0, sum_q} + {9'b0, data_i};

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            sum_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (en_i) begin
            sum_d = add[15:0];
            ovf_d = ovf_q | add[16];
            if (!(CNT_SAT && cnt_q == 8'hFF))
                cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum_o = sum_q;
    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/tt_um_labgroup17_frame_reader.sv
// Frame reader tile: accumulates a framed byte stream, then hands the sum out a byte per ack edge.
module tt_um_labgroup17_frame_reader
    import tt_lab17_pkg::*;
#(
    parameter bit CNT_SAT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    state_e      state_q, state_d;
    logic        ack_q;
    logic        in_valid, in_last, rd_ack;
    logic        ack_rise, in_ready, xfer, clr;
    logic [15:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
    logic        unused_uio;

    assign in_valid   = uio_in[UIO_VALID];
    assign in_last    = uio_in[UIO_LAST];
    assign rd_ack     = uio_in[UIO_ACK];
    assign unused_uio = &{1'b0, uio_in[7:3]};

    // ack_q follows the pin even while disabled so a held level never looks like a fresh edge.
    always_ff @(posedge clk) begin
        if (!rst_n) ack_q <= 1'b0;
        else        ack_q <= rd_ack;
    end

    assign ack_rise = ena & rd_ack & ~ack_q;
    assign in_ready = ena & (state_q == ST_ACC);
    assign xfer     = in_valid & in_ready;
    assign clr      = (state_q == ST_RES_HI) & ack_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_ACC;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:    if (xfer && in_last) state_d = ST_RES_LO;
            ST_RES_LO: if (ack_rise)        state_d = ST_RES_HI;
            ST_RES_HI: if (ack_rise)        state_d = ST_ACC;
            default:                        state_d = ST_ACC;
        endcase
    end

    always_comb begin
        uo_out  = cnt;
        uio_out = '0;
        case (state_q)
            ST_RES_LO: uo_out = sum[7:0];
            ST_RES_HI: uo_out = sum[15:8];
            default:   uo_out = cnt;
        endcase
        uio_out[UIO_READY]     = in_ready;
        uio_out[UIO_RES_VALID] = (state_q == ST_RES_LO) || (state_q == ST_RES_HI);
        uio_out[UIO_RES_HI]    = (state_q == ST_RES_HI);
        uio_out[UIO_OVF]       = ovf;
    end

    assign uio_oe = UIO_OE_MASK;

    frame_accumulator #(.CNT_SAT(CNT_SAT)) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .en_i   (xfer),
        .data_i (ui_in),
        .sum_o  (sum),
        .cnt_o  (cnt),
        .ovf_o  (ovf)
    );

endmodule
